// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline memory-access stage with a small word-addressed
// data memory, byte/half/word/full loads and stores, and optional wait states.
//
// Ports:
//   clk                 - clock; all state changes on its falling edge
//   resetN              - synchronous active-low reset
//   writeBackControlIn  - write-back control from the previous stage
//   memAccessControl    - bit1 = read, bit0 = write (both set is illegal)
//   accessSize          - 00 byte, 01 half, 10 word (32b), 11 full width
//   signExtend          - 1 sign-extends narrow loads, 0 zero-extends
//   resultIn            - ALU result, used as the byte address
//   writeData           - store data, least-significant bytes first
//   rdIn                - destination register tag
//   writeBackControlOut - registered write-back control (00 on bubble/fault)
//   readData            - registered extended load data (0 when not a load)
//   resultOut           - registered copy of resultIn
//   rdOut               - registered copy of rdIn
//   busy                - 1 while a multi-cycle access is pending
//   fault               - 1-cycle access-fault pulse
//
// Build option: define MEM_ACCESS_FAULT_EN to flag misaligned, out-of-range,
// unsupported-size and read+write accesses on 'fault'. Without it 'fault' is
// tied to 0, misaligned lanes are truncated and upper address bits wrap.

module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int LATENCY    = 0,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [1:0]            writeBackControlIn,
    input  logic [1:0]            memAccessControl,
    input  logic [1:0]            accessSize,
    input  logic                  signExtend,
    input  logic [DATA_WIDTH-1:0] resultIn,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [RD_WIDTH-1:0]   rdIn,
    output logic [1:0]            writeBackControlOut,
    output logic [DATA_WIDTH-1:0] readData,
    output logic [DATA_WIDTH-1:0] resultOut,
    output logic [RD_WIDTH-1:0]   rdOut,
    output logic                  busy,
    output logic                  fault
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int B     = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_t;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // Power-up contents: word i holds the value i. Reset leaves it alone.
    function automatic mem_t f_mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = DATA_WIDTH'(i);
        end
        return m;
    endfunction

    mem_t r_mem = f_mem_init();

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;

    logic [1:0]            r_wb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_res;
    logic [RD_WIDTH-1:0]   r_rdo;
    logic                  r_busy;

    logic [1:0]            w_wb_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic [DATA_WIDTH-1:0] w_res_nxt;
    logic [RD_WIDTH-1:0]   w_rdo_nxt;
    logic                  w_busy_nxt;

    logic                  w_exec;
    logic                  w_bubble;
    logic                  w_acc;
    logic                  w_illegal;
    logic                  w_flt;
    logic                  w_bad;
    logic                  w_load_op;
    logic                  w_we;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [B-1:0]          w_lane;
    logic [B-1:0]          w_amask;
    logic [B-1:0]          w_lane_a;
    logic [B:0]            w_nbytes;
    logic [B+2:0]          w_sh_amt;
    logic [2*NB-1:0]       w_bemask;
    logic [NB-1:0]         w_be;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_wd_sh;
    logic [DATA_WIDTH-1:0] w_new;
    logic [DATA_WIDTH-1:0] w_rd_sh;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_sign;
    logic                  w_fill;

    // ------------------------------------------------------------------
    // Address decode and lane selection
    // ------------------------------------------------------------------
    assign w_acc     = |memAccessControl;
    assign w_illegal = &memAccessControl;
    assign w_load_op = (memAccessControl == 2'b10);
    assign w_idx     = resultIn[DEPTH_LOG2+B-1:B];
    assign w_lane    = resultIn[B-1:0];

    always_comb begin
        w_nbytes = (B+1)'(NB);
        unique case (accessSize)
            2'b00:   w_nbytes = (B+1)'(1);
            2'b01:   w_nbytes = (B+1)'(2);
            2'b10:   w_nbytes = (B+1)'(4);
            2'b11:   w_nbytes = (B+1)'(NB);
        endcase
    end

    // Natural alignment mask; a full-width access wraps to an all-zero mask.
    assign w_amask  = ~(w_nbytes[B-1:0] - B'(1));
    assign w_lane_a = w_lane & w_amask;
    assign w_sh_amt = {w_lane_a, 3'b000};

    assign w_bemask = ((2*NB)'(1) << w_nbytes) - (2*NB)'(1);
    assign w_be     = w_bemask[NB-1:0] << w_lane_a;

    // ------------------------------------------------------------------
    // Store merge and load extraction
    // ------------------------------------------------------------------
    assign w_old   = r_mem[w_idx];
    assign w_wd_sh = writeData << w_sh_amt;
    assign w_rd_sh = w_old >> w_sh_amt;

    always_comb begin
        w_new = w_old;
        for (int j = 0; j < NB; j++) begin
            if (w_be[j]) begin
                w_new[8*j +: 8] = w_wd_sh[8*j +: 8];
            end
        end
    end

    always_comb begin
        w_sign = 1'b0;
        for (int j = 0; j < NB; j++) begin
            if (int'(w_nbytes) == j + 1) begin
                w_sign = w_rd_sh[8*j+7];
            end
        end
    end

    assign w_fill = signExtend & w_sign;

    always_comb begin
        w_load = '0;
        for (int j = 0; j < NB; j++) begin
            if (j < int'(w_nbytes)) begin
                w_load[8*j +: 8] = w_rd_sh[8*j +: 8];
            end else begin
                w_load[8*j +: 8] = {8{w_fill}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Fault detection (optional)
    // ------------------------------------------------------------------
`ifdef MEM_ACCESS_FAULT_EN
    logic w_misalign;
    logic w_size_bad;
    logic w_upper;
    logic r_fault;

    assign w_misalign = (w_lane & ~w_amask) != '0;
    assign w_size_bad = (accessSize == 2'b11) && (DATA_WIDTH == 32);
    assign w_upper    = resultIn[DATA_WIDTH-1:DEPTH_LOG2+B] != '0;
    assign w_flt      = w_acc
                      & (w_illegal | w_misalign | w_size_bad | w_upper);

    always_ff @(negedge clk) begin
        if (!resetN) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_exec & w_flt;
        end
    end

    assign fault = r_fault;
`else
    assign w_flt = 1'b0;
    assign fault = 1'b0;
`endif

    assign w_bad = w_illegal | w_flt;

    // ------------------------------------------------------------------
    // Control FSM: next state, counter and output register values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_exec      = 1'b0;
        w_bubble    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_acc && (LATENCY != 0)) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = 4'd1;
                    w_bubble    = 1'b1;
                end else begin
                    w_exec = 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt == LAT4) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_exec      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
        endcase

        w_wb_nxt    = r_wb;
        w_rdata_nxt = r_rdata;
        w_res_nxt   = r_res;
        w_rdo_nxt   = r_rdo;
        w_busy_nxt  = r_busy;
        if (w_exec) begin
            w_wb_nxt    = w_bad ? 2'b00 : writeBackControlIn;
            w_rdata_nxt = (w_load_op && !w_bad) ? w_load : '0;
            w_res_nxt   = resultIn;
            w_rdo_nxt   = rdIn;
            w_busy_nxt  = 1'b0;
        end else if (w_bubble) begin
            w_wb_nxt    = 2'b00;
            w_rdata_nxt = '0;
            w_busy_nxt  = 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (!resetN) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_wb    <= 2'b00;
            r_rdata <= '0;
            r_res   <= '0;
            r_rdo   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wb    <= w_wb_nxt;
            r_rdata <= w_rdata_nxt;
            r_res   <= w_res_nxt;
            r_rdo   <= w_rdo_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // A reset edge suppresses the write, so an aborted store never lands.
    assign w_we = w_exec & resetN & memAccessControl[0] & ~w_bad;

    always_ff @(negedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_new;
        end
    end

    assign writeBackControlOut = r_wb;
    assign readData            = r_rdata;
    assign resultOut           = r_res;
    assign rdOut               = r_rdo;
    assign busy                = r_busy;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with a byte-level
// reference model; one instance with LATENCY=0 and one with LATENCY=3.

module tb_mem_access_unit;

    typedef struct packed {
        logic [1:0]  wbc;
        logic [1:0]  mac;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  rd;
    } in_t;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] rdat;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        busy;
        logic        flt;
        int          rem;
    } st_t;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] WR   = 2'b01;
    localparam logic [1:0] RD   = 2'b10;
    localparam logic [1:0] BOTH = 2'b11;
    localparam logic [1:0] SB   = 2'b00;
    localparam logic [1:0] SH   = 2'b01;
    localparam logic [1:0] SW   = 2'b10;
    localparam logic [1:0] SF   = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0;
    logic rst3;
    in_t  in0;
    in_t  in3;

    logic [1:0]  wb0, wb3;
    logic [31:0] rdat0, rdat3;
    logic [31:0] res0, res3;
    logic [4:0]  rdo0, rdo3;
    logic        busy0, busy3;
    logic        flt0, flt3;

    logic [31:0] mem [2][8];
    st_t         st [2];

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    mem_access_unit #(
        .DATA_WIDTH(32), .DEPTH_LOG2(3), .LATENCY(0), .RD_WIDTH(5)
    ) u_dut0 (
        .clk(clk), .resetN(rst0),
        .writeBackControlIn(in0.wbc), .memAccessControl(in0.mac),
        .accessSize(in0.sz), .signExtend(in0.sx),
        .resultIn(in0.res), .writeData(in0.wd), .rdIn(in0.rd),
        .writeBackControlOut(wb0), .readData(rdat0),
        .resultOut(res0), .rdOut(rdo0), .busy(busy0), .fault(flt0)
    );

    mem_access_unit #(
        .DATA_WIDTH(32), .DEPTH_LOG2(3), .LATENCY(3), .RD_WIDTH(5)
    ) u_dut3 (
        .clk(clk), .resetN(rst3),
        .writeBackControlIn(in3.wbc), .memAccessControl(in3.mac),
        .accessSize(in3.sz), .signExtend(in3.sx),
        .resultIn(in3.res), .writeData(in3.wd), .rdIn(in3.rd),
        .writeBackControlOut(wb3), .readData(rdat3),
        .resultOut(res3), .rdOut(rdo3), .busy(busy3), .fault(flt3)
    );

    function automatic in_t mk(input logic [1:0] wbc, input logic [1:0] mac,
                               input logic [1:0] sz, input logic sx,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [4:0] rd);
        in_t x;
        x.wbc = wbc;
        x.mac = mac;
        x.sz  = sz;
        x.sx  = sx;
        x.res = a;
        x.wd  = wd;
        x.rd  = rd;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference behaviour of one completed access, byte by byte.
    task automatic exec(input int k, input in_t x);
        int          n;
        int          lane;
        int          idx;
        logic [31:0] val;
        logic        rd;
        logic        wr;
        logic        flt;
        logic        bad;
        rd   = x.mac[1];
        wr   = x.mac[0];
        n    = (x.sz == SB) ? 1 : (x.sz == SH) ? 2 : 4;
        lane = int'(x.res[1:0]);
        idx  = int'(x.res[4:2]);
        flt  = 1'b0;
`ifdef MEM_ACCESS_FAULT_EN
        if (rd || wr) begin
            flt = (rd && wr) || (lane % n != 0) || (x.sz == SF)
                || (x.res[31:5] != 27'd0);
        end
`endif
        lane = lane - lane % n;
        bad  = (rd && wr) || flt;
        val  = 32'd0;
        for (int b = 0; b < n; b++) begin
            val[8*b +: 8] = mem[k][idx][8*(lane+b) +: 8];
        end
        if (x.sx && n < 4 && val[8*n-1]) begin
            val = val | (32'hFFFF_FFFF << (8*n));
        end
        if (wr && !bad) begin
            for (int b = 0; b < n; b++) begin
                mem[k][idx][8*(lane+b) +: 8] = x.wd[8*b +: 8];
            end
        end
        st[k].wb   = bad ? 2'b00 : x.wbc;
        st[k].rdat = (rd && !bad) ? val : 32'd0;
        st[k].res  = x.res;
        st[k].rdo  = x.rd;
        st[k].flt  = flt;
        st[k].busy = 1'b0;
    endtask

    task automatic step(input int k, input int lat, input logic rstn,
                        input in_t x);
        if (!rstn) begin
            st[k].wb   = 2'b00;
            st[k].rdat = 32'd0;
            st[k].res  = 32'd0;
            st[k].rdo  = 5'd0;
            st[k].busy = 1'b0;
            st[k].flt  = 1'b0;
            st[k].rem  = 0;
        end else if (st[k].rem > 0) begin
            st[k].rem--;
            if (st[k].rem == 0) begin
                exec(k, x);
            end
        end else if (x.mac != NONE && lat > 0) begin
            st[k].rem  = lat;
            st[k].busy = 1'b1;
            st[k].wb   = 2'b00;
            st[k].rdat = 32'd0;
            st[k].flt  = 1'b0;
        end else begin
            exec(k, x);
        end
    endtask

    task automatic check_dut(input int k, input logic [1:0] wb,
                             input logic [31:0] rdat, input logic [31:0] res,
                             input logic [4:0] rdo, input logic busy,
                             input logic flt);
        string p;
        p = $sformatf("dut%0d_", k);
        chk({p, "busy"}, {31'd0, busy}, {31'd0, st[k].busy});
        chk({p, "wb"}, {30'd0, wb}, {30'd0, st[k].wb});
        chk({p, "readData"}, rdat, st[k].rdat);
        chk({p, "fault"}, {31'd0, flt}, {31'd0, st[k].flt});
        if (!st[k].busy) begin
            chk({p, "resultOut"}, res, st[k].res);
            chk({p, "rdOut"}, {27'd0, rdo}, {27'd0, st[k].rdo});
        end
    endtask

    always @(negedge clk) begin
        step(0, 0, rst0, in0);
        step(1, 3, rst3, in3);
    end

    always @(posedge clk) begin
        if (started) begin
            check_dut(0, wb0, rdat0, res0, rdo0, busy0, flt0);
            check_dut(1, wb3, rdat3, res3, rdo3, busy3, flt3);
        end
    end

    task automatic op0(input in_t x);
        in0 = x;
        @(posedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                mem[k][i] = 32'(i);
            end
            st[k].rem = 0;
        end
        rst0 = 1'b0;
        rst3 = 1'b0;
        in0  = '0;
        in3  = '0;
        repeat (2) @(posedge clk);
        started = 1'b1;
        chk("rst_busy3", {31'd0, busy3}, 32'd0);
        chk("rst_wb0", {30'd0, wb0}, 32'd0);
        chk("rst_rdata0", rdat0, 32'd0);
        chk("rst_res3", res3, 32'd0);
        chk("rst_fault0", {31'd0, flt0}, 32'd0);
        rst0 = 1'b1;
        rst3 = 1'b1;
        @(posedge clk);

        op0(mk(2'b11, RD, SW, 1'b0, 32'h14, 32'd0, 5'd7));
        chk("lw14_rdata", rdat0, 32'd5);
        chk("lw14_busy", {31'd0, busy0}, 32'd0);
        chk("lw14_wb", {30'd0, wb0}, 32'd3);
        op0(mk(2'b01, WR, SB, 1'b0, 32'h09, 32'h0000_00AB, 5'd1));
        chk("sb09_rdata", rdat0, 32'd0);
        op0(mk(2'b01, RD, SW, 1'b0, 32'h08, 32'd0, 5'd2));
        chk("lw08_rdata", rdat0, 32'h0000_AB02);
        op0(mk(2'b01, RD, SB, 1'b1, 32'h09, 32'd0, 5'd2));
        chk("lb09_signed", rdat0, 32'hFFFF_FFAB);
        op0(mk(2'b01, RD, SB, 1'b0, 32'h09, 32'd0, 5'd2));
        chk("lb09_unsigned", rdat0, 32'h0000_00AB);

        op0(mk(2'b01, WR, SH, 1'b0, 32'h05, 32'hBEEF_1234, 5'd3));
`ifdef MEM_ACCESS_FAULT_EN
        chk("sh05_fault", {31'd0, flt0}, 32'd1);
        chk("sh05_wb", {30'd0, wb0}, 32'd0);
`else
        chk("sh05_fault", {31'd0, flt0}, 32'd0);
`endif
        op0(mk(2'b01, RD, SW, 1'b0, 32'h04, 32'd0, 5'd4));
`ifdef MEM_ACCESS_FAULT_EN
        chk("lw04_after_sh", rdat0, 32'd1);
        chk("fault_one_cycle", {31'd0, flt0}, 32'd0);
`else
        chk("lw04_after_sh", rdat0, 32'h0000_1234);
`endif

        op0(mk(2'b10, WR, SW, 1'b0, 32'h18, 32'h8000_8001, 5'd5));
        op0(mk(2'b10, RD, SH, 1'b1, 32'h1A, 32'd0, 5'd6));
        chk("lh1a_signed", rdat0, 32'hFFFF_8000);
        op0(mk(2'b10, RD, SH, 1'b0, 32'h18, 32'd0, 5'd6));
        chk("lh18_unsigned", rdat0, 32'h0000_8001);
        op0(mk(2'b10, RD, SB, 1'b1, 32'h1B, 32'd0, 5'd6));
        chk("lb1b_signed", rdat0, 32'hFFFF_FF80);
        op0(mk(2'b10, RD, SH, 1'b0, 32'h1B, 32'd0, 5'd6));
`ifdef MEM_ACCESS_FAULT_EN
        chk("lh1b_misalign", rdat0, 32'd0);
`else
        chk("lh1b_misalign", rdat0, 32'h0000_8000);
`endif

        op0(mk(2'b11, BOTH, SW, 1'b0, 32'h0C, 32'hFFFF_FFFF, 5'd8));
        chk("illegal_wb", {30'd0, wb0}, 32'd0);
        chk("illegal_rdata", rdat0, 32'd0);
        op0(mk(2'b11, RD, SW, 1'b0, 32'h0C, 32'd0, 5'd9));
        chk("lw0c_unchanged", rdat0, 32'd3);
        op0(mk(2'b11, RD, SW, 1'b0, 32'h2C, 32'd0, 5'd9));
`ifdef MEM_ACCESS_FAULT_EN
        chk("lw2c_upper", rdat0, 32'd0);
`else
        chk("lw2c_upper", rdat0, 32'd3);
`endif
        op0(mk(2'b11, RD, SF, 1'b0, 32'h10, 32'd0, 5'd9));
`ifdef MEM_ACCESS_FAULT_EN
        chk("lfull10", rdat0, 32'd0);
`else
        chk("lfull10", rdat0, 32'd4);
`endif
        op0(mk(2'b10, NONE, SW, 1'b0, 32'h1234_5678, 32'd0, 5'd31));
        chk("pass_wb", {30'd0, wb0}, 32'd2);
        chk("pass_res", res0, 32'h1234_5678);
        chk("pass_rd", {27'd0, rdo0}, 32'd31);
        chk("pass_rdata", rdat0, 32'd0);
        in0 = '0;

        in3 = mk(2'b10, RD, SW, 1'b0, 32'h0C, 32'd0, 5'd12);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            chk($sformatf("lat_busy_%0d", i), {31'd0, busy3}, 32'd1);
            chk($sformatf("lat_bubble_%0d", i), {30'd0, wb3}, 32'd0);
        end
        @(posedge clk);
        chk("lat_busy_end", {31'd0, busy3}, 32'd0);
        chk("lat_rdata", rdat3, 32'd3);
        chk("lat_wb", {30'd0, wb3}, 32'd2);

        in3 = mk(2'b01, WR, SW, 1'b0, 32'h10, 32'h1122_3344, 5'd13);
        @(posedge clk);
        in3 = mk(2'b11, WR, SB, 1'b0, 32'h00, 32'h0000_0055, 5'd14);
        repeat (2) @(posedge clk);
        in3 = mk(2'b01, WR, SW, 1'b0, 32'h10, 32'h1122_3344, 5'd13);
        @(posedge clk);
        chk("lat_sw_busy", {31'd0, busy3}, 32'd0);
        chk("lat_sw_wb", {30'd0, wb3}, 32'd1);
        in3 = mk(2'b01, RD, SW, 1'b0, 32'h10, 32'd0, 5'd15);
        repeat (4) @(posedge clk);
        chk("lat_lw10", rdat3, 32'h1122_3344);
        in3 = mk(2'b01, RD, SW, 1'b0, 32'h00, 32'd0, 5'd15);
        repeat (4) @(posedge clk);
        chk("lat_lw00", rdat3, 32'd0);

        in3 = mk(2'b11, WR, SW, 1'b0, 32'h14, 32'hDEAD_BEEF, 5'd16);
        repeat (2) @(posedge clk);
        rst3 = 1'b0;
        in3  = '0;
        @(posedge clk);
        chk("abort_busy", {31'd0, busy3}, 32'd0);
        chk("abort_wb", {30'd0, wb3}, 32'd0);
        chk("abort_rdata", rdat3, 32'd0);
        chk("abort_res", res3, 32'd0);
        chk("abort_rd", {27'd0, rdo3}, 32'd0);
        chk("abort_fault", {31'd0, flt3}, 32'd0);
        rst3 = 1'b1;
        in3  = mk(2'b01, RD, SW, 1'b0, 32'h14, 32'd0, 5'd17);
        repeat (4) @(posedge clk);
        chk("abort_reload", rdat3, 32'd5);
        in3 = '0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
